// File: rtl/ascon_regfile_if.sv
// Bus bundle for the Ascon register file: writeback/serial-load inputs, state words,
// readout control, and register/readout outputs. The master drives, the slave is the regfile.
interface ascon_regfile_if;
  logic         wrback_en;
  logic [1:0]   wrback_sel;
  logic [127:0] wrback_val;
  logic         sin_en;
  logic [1:0]   sin_sel;
  logic         sin_bit;
  logic [63:0]  S_0_reg;
  logic [63:0]  S_1_reg;
  logic [63:0]  S_2_reg;
  logic [63:0]  S_3_reg;
  logic [63:0]  S_4_reg;
  logic         rd_start;
  logic [2:0]   rd_sel;
  logic [127:0] reg0_128b;
  logic [127:0] reg1_128b;
  logic [127:0] reg2_128b;
  logic         sout;
  logic         sout_valid;
  logic         rd_busy;
  logic         rd_done;

  modport master (
    output wrback_en, wrback_sel, wrback_val,
    output sin_en, sin_sel, sin_bit,
    output S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg,
    output rd_start, rd_sel,
    input  reg0_128b, reg1_128b, reg2_128b,
    input  sout, sout_valid, rd_busy, rd_done
  );

  modport slave (
    input  wrback_en, wrback_sel, wrback_val,
    input  sin_en, sin_sel, sin_bit,
    input  S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg,
    input  rd_start, rd_sel,
    output reg0_128b, reg1_128b, reg2_128b,
    output sout, sout_valid, rd_busy, rd_done
  );
endinterface

// File: rtl/ascon_regfile.sv
// Three 128-bit Ascon registers with writeback/serial load and an MSB-first serial readout.
// Define ASCON_READOUT_PARITY_EN to append an even-parity bit (PAR state) after each readout.
//
// state | meaning
// IDLE  | waiting for rd_start with a valid rd_sel
// LOAD  | snapshot source into buffer, preset bit counter to N-1
// SHIFT | drive buf[127] on sout, shift left, count down
// PAR   | drive accumulated parity bit (parity build only)
// DONE  | one-cycle rd_done pulse
module ascon_regfile (
  input  logic                 clk,
  input  logic                 rst_n,
  ascon_regfile_if.slave       bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
`ifdef ASCON_READOUT_PARITY_EN
    ST_PAR   = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_regs [3];
  logic [2:0]   r_sel;
  logic [127:0] r_buf;
  logic [6:0]   r_cnt;
  logic [127:0] w_src;
  logic         w_start_ok;
  logic         w_sout;
  logic         w_sout_valid;
  logic         w_rd_done;
  logic         w_unused;
`ifdef ASCON_READOUT_PARITY_EN
  logic         r_par;
`endif

  // S_4 is part of the state bundle but deliberately not readable
  assign w_unused = ^bus.S_4_reg;

  // Writeback takes priority over a serial bit aimed at the same register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bus.wrback_en && (bus.wrback_sel == 2'(i))) begin
          r_regs[i] <= bus.wrback_val;
        end else if (bus.sin_en && (bus.sin_sel == 2'(i))) begin
          r_regs[i] <= {r_regs[i][126:0], bus.sin_bit};
        end
      end
    end
  end

  assign bus.reg0_128b = r_regs[0];
  assign bus.reg1_128b = r_regs[1];
  assign bus.reg2_128b = r_regs[2];

  assign w_start_ok = bus.rd_start && (bus.rd_sel != 3'd3);

  always_comb begin
    w_src = '0;
    case (r_sel)
      3'd0:    w_src = r_regs[0];
      3'd1:    w_src = r_regs[1];
      3'd2:    w_src = r_regs[2];
      3'd4:    w_src = {bus.S_0_reg, 64'd0};
      3'd5:    w_src = {bus.S_1_reg, 64'd0};
      3'd6:    w_src = {bus.S_2_reg, 64'd0};
      3'd7:    w_src = {bus.S_3_reg, 64'd0};
      default: w_src = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sout       = 1'b0;
    w_sout_valid = 1'b0;
    w_rd_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_sout       = r_buf[127];
        w_sout_valid = 1'b1;
        if (r_cnt == 7'd0) begin
`ifdef ASCON_READOUT_PARITY_EN
          w_state_nxt = ST_PAR;
`else
          w_state_nxt = ST_DONE;
`endif
        end
      end
`ifdef ASCON_READOUT_PARITY_EN
      ST_PAR: begin
        w_sout       = r_par;
        w_sout_valid = 1'b1;
        w_state_nxt  = ST_DONE;
      end
`endif
      ST_DONE: begin
        w_rd_done   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Readout datapath; the buffer is a LOAD-time snapshot, so later writes cannot disturb it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel <= '0;
      r_buf <= '0;
      r_cnt <= '0;
`ifdef ASCON_READOUT_PARITY_EN
      r_par <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) r_sel <= bus.rd_sel;
        end
        ST_LOAD: begin
          r_buf <= w_src;
          r_cnt <= r_sel[2] ? 7'd63 : 7'd127;
`ifdef ASCON_READOUT_PARITY_EN
          r_par <= 1'b0;
`endif
        end
        ST_SHIFT: begin
          r_buf <= {r_buf[126:0], 1'b0};
          r_cnt <= r_cnt - 7'd1;
`ifdef ASCON_READOUT_PARITY_EN
          r_par <= r_par ^ r_buf[127];
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.sout       = w_sout;
  assign bus.sout_valid = w_sout_valid;
  assign bus.rd_busy    = (r_state != ST_IDLE);
  assign bus.rd_done    = w_rd_done;

endmodule

// File: tb/tb_ascon_regfile.sv
// Self-checking bench for ascon_regfile: random stimulus against an array/queue reference model.
module tb_ascon_regfile;
`ifdef ASCON_READOUT_PARITY_EN
  localparam int PAR_EXTRA = 1;
`else
  localparam int PAR_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ascon_regfile_if bus();
  ascon_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] m_reg [3];
  logic [63:0]  s_words [5];

  assign bus.S_0_reg = s_words[0];
  assign bus.S_1_reg = s_words[1];
  assign bus.S_2_reg = s_words[2];
  assign bus.S_3_reg = s_words[3];
  assign bus.S_4_reg = s_words[4];

  logic cap_bits[$];
  int   cap_done_cnt, cap_done_cyc, cap_busy_first, cap_busy_last, cap_busy_cnt;
  bit   cap_stray;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Model: advance one clock using the inputs currently on the bus
  task automatic step();
    logic [127:0] nx [3];
    for (int i = 0; i < 3; i++) nx[i] = m_reg[i];
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) nx[i] = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bus.wrback_en && bus.wrback_sel == 2'(i)) nx[i] = bus.wrback_val;
        else if (bus.sin_en && bus.sin_sel == 2'(i)) nx[i] = (m_reg[i] << 1) | 128'(bus.sin_bit);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) m_reg[i] = nx[i];
  endtask

  task automatic idle_inputs();
    bus.wrback_en = 1'b0; bus.wrback_sel = '0; bus.wrback_val = '0;
    bus.sin_en = 1'b0; bus.sin_sel = '0; bus.sin_bit = 1'b0;
    bus.rd_start = 1'b0; bus.rd_sel = '0;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [127:0] val);
    bus.wrback_en = 1'b1; bus.wrback_sel = sel; bus.wrback_val = val;
    step();
    bus.wrback_en = 1'b0;
  endtask

  function automatic logic [127:0] src_of(input logic [2:0] sel);
    if (sel < 3'd3) return m_reg[sel[1:0]];
    if (sel == 3'd3) return '0;
    return {s_words[sel - 3'd4], 64'd0};
  endfunction

  // Starts a readout and records 200 cycles of output; cycle 1 is the cycle after rd_start
  task automatic run_readout(input logic [2:0] sel, input int wb_at, input logic [1:0] wb_sel,
                             input logic [127:0] wb_val, input int start_at);
    cap_bits.delete();
    cap_done_cnt = 0; cap_done_cyc = -1; cap_busy_first = -1; cap_busy_last = -1;
    cap_busy_cnt = 0; cap_stray = 1'b0;
    bus.rd_sel = sel; bus.rd_start = 1'b1;
    step();
    bus.rd_start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (bus.sout_valid) cap_bits.push_back(bus.sout);
      else if (bus.sout) cap_stray = 1'b1;
      if (bus.rd_busy) begin
        if (cap_busy_first < 0) cap_busy_first = c;
        cap_busy_last = c;
        cap_busy_cnt++;
      end
      if (bus.rd_done) begin
        cap_done_cnt++;
        cap_done_cyc = c;
      end
      bus.wrback_en = (c == wb_at); bus.wrback_sel = wb_sel; bus.wrback_val = wb_val;
      bus.rd_start = (c == start_at);
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    n_tests++;
    if ({bus.reg0_128b, bus.reg1_128b, bus.reg2_128b} !== 384'd0) begin
      n_fail++; $display("FAIL reset_regs: got %h %h %h expected 0", bus.reg0_128b, bus.reg1_128b, bus.reg2_128b);
    end
    n_tests++;
    if ({bus.sout, bus.sout_valid, bus.rd_busy, bus.rd_done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b expected 0000", {bus.sout, bus.sout_valid, bus.rd_busy, bus.rd_done});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_writeback();
    logic [127:0] v;
    v = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    write_reg(2'd1, v);
    n_tests++;
    if (bus.reg1_128b !== v || bus.reg0_128b !== '0 || bus.reg2_128b !== '0) begin
      n_fail++; $display("FAIL wb_directed: got %h/%h/%h expected 0/%h/0", bus.reg0_128b, bus.reg1_128b, bus.reg2_128b, v);
    end
    for (int k = 0; k < 16; k++) begin
      write_reg(2'($urandom_range(0, 3)), rand128());
      n_tests++;
      if (bus.reg0_128b !== m_reg[0] || bus.reg1_128b !== m_reg[1] || bus.reg2_128b !== m_reg[2]) begin
        n_fail++; $display("FAIL wb_random: got %h/%h/%h expected %h/%h/%h", bus.reg0_128b, bus.reg1_128b,
                           bus.reg2_128b, m_reg[0], m_reg[1], m_reg[2]);
      end
    end
  endtask

  task automatic test_serial_load();
    logic [127:0] exp_aa;
    exp_aa = {32{4'hA}};
    for (int k = 0; k < 128; k++) begin
      bus.sin_en = 1'b1; bus.sin_sel = 2'd2; bus.sin_bit = (k % 2 == 0);
      step();
    end
    bus.sin_en = 1'b0;
    n_tests++;
    if (bus.reg2_128b !== exp_aa) begin
      n_fail++; $display("FAIL sin_alt: got %h expected %h", bus.reg2_128b, exp_aa);
    end
    n_tests++;
    if (bus.reg0_128b !== m_reg[0] || bus.reg1_128b !== m_reg[1]) begin
      n_fail++; $display("FAIL sin_others: got %h/%h expected %h/%h", bus.reg0_128b, bus.reg1_128b, m_reg[0], m_reg[1]);
    end
  endtask

  task automatic test_collision();
    logic [127:0] v, r2;
    v = rand128();
    bus.wrback_en = 1'b1; bus.wrback_sel = 2'd1; bus.wrback_val = v;
    bus.sin_en = 1'b1; bus.sin_sel = 2'd1; bus.sin_bit = 1'b1;
    step();
    n_tests++;
    if (bus.reg1_128b !== v) begin
      n_fail++; $display("FAIL collide_same: got %h expected %h", bus.reg1_128b, v);
    end
    v = rand128(); r2 = m_reg[2];
    bus.wrback_sel = 2'd0; bus.wrback_val = v; bus.sin_sel = 2'd2; bus.sin_bit = 1'b1;
    step();
    idle_inputs();
    n_tests++;
    if (bus.reg0_128b !== v || bus.reg2_128b !== {r2[126:0], 1'b1}) begin
      n_fail++; $display("FAIL collide_diff: got %h/%h expected %h/%h", bus.reg0_128b, bus.reg2_128b, v, {r2[126:0], 1'b1});
    end
    for (int k = 0; k < 40; k++) begin
      bus.wrback_en = 1'($urandom_range(0, 1)); bus.wrback_sel = 2'($urandom_range(0, 3));
      bus.wrback_val = rand128();
      bus.sin_en = 1'($urandom_range(0, 1)); bus.sin_sel = 2'($urandom_range(0, 3));
      bus.sin_bit = 1'($urandom_range(0, 1));
      step();
      n_tests++;
      if (bus.reg0_128b !== m_reg[0] || bus.reg1_128b !== m_reg[1] || bus.reg2_128b !== m_reg[2]) begin
        n_fail++; $display("FAIL mixed_random: got %h/%h/%h expected %h/%h/%h", bus.reg0_128b, bus.reg1_128b,
                           bus.reg2_128b, m_reg[0], m_reg[1], m_reg[2]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_readout_state();
    logic [127:0] src;
    int errs;
    s_words[1] = 64'h8000_0000_0000_0001;
    src = src_of(3'd5);
    run_readout(3'd5, -1, 2'd0, '0, -1);
    errs = 0;
    for (int k = 0; k < 64 && k < cap_bits.size(); k++) if (cap_bits[k] !== src[127 - k]) errs++;
    n_tests++;
    if (cap_bits.size() != 64 + PAR_EXTRA || errs != 0) begin
      n_fail++; $display("FAIL s1_bits: got %0d bits %0d wrong expected %0d bits", cap_bits.size(), errs, 64 + PAR_EXTRA);
    end
    n_tests++;
    if (cap_done_cnt != 1 || cap_done_cyc != 66 + PAR_EXTRA) begin
      n_fail++; $display("FAIL s1_done: got %0d pulses at %0d expected 1 at %0d", cap_done_cnt, cap_done_cyc, 66 + PAR_EXTRA);
    end
    n_tests++;
    if (cap_busy_first != 1 || cap_busy_last != 66 + PAR_EXTRA || cap_busy_cnt != 66 + PAR_EXTRA || cap_stray) begin
      n_fail++; $display("FAIL s1_busy: got %0d..%0d (%0d) stray=%0d expected 1..%0d", cap_busy_first, cap_busy_last,
                         cap_busy_cnt, cap_stray, 66 + PAR_EXTRA);
    end
  endtask

  task automatic test_readout_snapshot();
    int ones;
    write_reg(2'd0, {128{1'b1}});
    run_readout(3'd0, 10, 2'd0, '0, 20);
    ones = 0;
    for (int k = 0; k < 128 && k < cap_bits.size(); k++) if (cap_bits[k] === 1'b1) ones++;
    n_tests++;
    if (ones != 128 || cap_bits.size() != 128 + PAR_EXTRA) begin
      n_fail++; $display("FAIL snap_bits: got %0d ones of %0d bits expected 128 of %0d", ones, cap_bits.size(), 128 + PAR_EXTRA);
    end
    n_tests++;
    if (cap_done_cnt != 1 || cap_busy_cnt != 130 + PAR_EXTRA) begin
      n_fail++; $display("FAIL snap_noqueue: got %0d done %0d busy expected 1 done %0d busy", cap_done_cnt, cap_busy_cnt, 130 + PAR_EXTRA);
    end
    n_tests++;
    if (bus.reg0_128b !== 128'd0) begin
      n_fail++; $display("FAIL snap_reg0: got %h expected 0", bus.reg0_128b);
    end
  endtask

  task automatic test_reset_mid();
    int nbits, guard;
    bit done_seen;
    write_reg(2'd2, rand128());
    bus.rd_sel = 3'd2; bus.rd_start = 1'b1;
    step();
    bus.rd_start = 1'b0;
    nbits = 0; guard = 0; done_seen = 1'b0;
    while (nbits < 40 && guard < 100) begin
      step();
      guard++;
      if (bus.sout_valid) nbits++;
      if (bus.rd_done) done_seen = 1'b1;
    end
    n_tests++;
    if (nbits != 40) begin
      n_fail++; $display("FAIL rstmid_reach: got %0d bits expected 40", nbits);
    end
    rst_n = 1'b0;
    step();
    n_tests++;
    if ({bus.sout, bus.sout_valid, bus.rd_busy, bus.rd_done} !== 4'b0 || done_seen || bus.reg2_128b !== '0) begin
      n_fail++; $display("FAIL rstmid_outs: got %b done_seen=%0d reg2=%h expected 0000 0 0",
                         {bus.sout, bus.sout_valid, bus.rd_busy, bus.rd_done}, done_seen, bus.reg2_128b);
    end
    rst_n = 1'b1;
    run_readout(3'd2, -1, 2'd0, '0, -1);
    n_tests++;
    if (cap_done_cnt != 1 || cap_done_cyc != 130 + PAR_EXTRA || cap_bits.size() != 128 + PAR_EXTRA) begin
      n_fail++; $display("FAIL rstmid_restart: got %0d done at %0d, %0d bits expected 1 at %0d, %0d bits",
                         cap_done_cnt, cap_done_cyc, cap_bits.size(), 130 + PAR_EXTRA, 128 + PAR_EXTRA);
    end
  endtask

  task automatic test_parity_len();
    write_reg(2'd2, 128'h7);
    run_readout(3'd2, -1, 2'd0, '0, -1);
    n_tests++;
    if (cap_bits.size() != 128 + PAR_EXTRA || cap_bits.size() == 0 || cap_bits[cap_bits.size() - 1] !== 1'b1) begin
      n_fail++; $display("FAIL par_len: got %0d bits expected %0d ending in 1", cap_bits.size(), 128 + PAR_EXTRA);
    end
  endtask

  task automatic test_random_readouts();
    logic [2:0] sel;
    logic [127:0] src;
    int n, errs;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 5; i++) s_words[i] = {$urandom(), $urandom()};
      write_reg(2'($urandom_range(0, 2)), rand128());
      sel = (it == 3) ? 3'd3 : 3'($urandom_range(0, 7));
      src = src_of(sel);
      n = (sel < 3'd3) ? 128 : 64;
      run_readout(sel, -1, 2'd0, '0, -1);
      n_tests++;
      if (sel == 3'd3) begin
        if (cap_busy_cnt != 0 || cap_done_cnt != 0 || cap_bits.size() != 0) begin
          n_fail++; $display("FAIL rand_sel3: got busy=%0d done=%0d bits=%0d expected 0 0 0", cap_busy_cnt, cap_done_cnt, cap_bits.size());
        end
      end else begin
        errs = 0;
        for (int k = 0; k < n && k < cap_bits.size(); k++) if (cap_bits[k] !== src[127 - k]) errs++;
        if (PAR_EXTRA == 1 && cap_bits.size() == n + 1 && cap_bits[n] !== ($countones(src) % 2 == 1)) errs++;
        if (errs != 0 || cap_bits.size() != n + PAR_EXTRA || cap_done_cnt != 1 || cap_done_cyc != n + 2 + PAR_EXTRA
            || cap_stray) begin
          n_fail++; $display("FAIL rand_rd sel=%0d: got %0d bits %0d wrong done %0d@%0d expected %0d bits done 1@%0d",
                             sel, cap_bits.size(), errs, cap_done_cnt, cap_done_cyc, n + PAR_EXTRA, n + 2 + PAR_EXTRA);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m_reg[i] = '0;
    for (int i = 0; i < 5; i++) s_words[i] = '0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_writeback();
    test_serial_load();
    test_collision();
    test_readout_state();
    test_readout_snapshot();
    test_reset_mid();
    test_parity_len();
    test_random_readouts();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_regfile.md
ASCON_REGFILE -- requirements
Module: ascon_regfile

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The module SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 The module SHALL have the port wrback_en, input, 1 bit: writeback strobe from the Ascon core.
REQ-004 The module SHALL have the port wrback_sel, input, 2 bits: writeback target (0=reg0, 1=reg1, 2=reg2, 3=ignored).
REQ-005 The module SHALL have the port wrback_val, input, 128 bits: writeback data.
REQ-006 The module SHALL have the port sin_en, input, 1 bit: serial-load enable.
REQ-007 The module SHALL have the port sin_sel, input, 2 bits: serial-load target, same encoding as wrback_sel.
REQ-008 The module SHALL have the port sin_bit, input, 1 bit: serial-load data bit.
REQ-009 The module SHALL have the ports S_0_reg .. S_4_reg, inputs, 64 bits each: live Ascon state words.
REQ-010 The module SHALL have the port rd_start, input, 1 bit: request for a serial readout.
REQ-011 The module SHALL have the port rd_sel, input, 3 bits: readout source (0-2=reg0-reg2, 3=reserved, 4-7=S_0-S_3; S_4 is not readable).
REQ-012 The module SHALL have the ports reg0_128b, reg1_128b, reg2_128b, outputs, 128 bits each: register contents fed to the core.
REQ-013 The module SHALL have the port sout, output, 1 bit: serial readout data, MSB first.
REQ-014 The module SHALL have the port sout_valid, output, 1 bit: sout carries a valid bit.
REQ-015 The module SHALL have the port rd_busy, output, 1 bit: high whenever the readout FSM is not in IDLE.
REQ-016 The module SHALL have the port rd_done, output, 1 bit: one-cycle pulse at the end of a readout.

Function
REQ-017 Writeback: when wrback_en=1 and wrback_sel<3, the selected register SHALL take wrback_val on the next edge; with wrback_sel=3 no register changes.
REQ-018 Serial load: when sin_en=1 and sin_sel<3, the selected register SHALL become {reg[126:0], sin_bit} on the next edge.
REQ-019 When writeback and serial load target the same register in the same cycle, the writeback SHALL win and the serial bit SHALL be discarded; different targets SHALL both update.
REQ-020 The readout FSM SHALL have the states IDLE, LOAD, SHIFT, PAR and DONE.
REQ-021 In IDLE, rd_start=1 with a valid rd_sel SHALL latch rd_sel and move to LOAD; rd_sel=3 SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-022 In LOAD (one cycle), the 128-bit buffer SHALL capture the source: the register for reg0-reg2, or {S_n, 64'd0} for a state word; the bit counter SHALL be set to N-1, with N=128 for registers and N=64 for state words.
REQ-023 In SHIFT, the outputs SHALL be sout=buf[127] and sout_valid=1; the buffer SHALL shift left one bit per cycle; the counter SHALL decrement; when the counter equals 0, the FSM SHALL go to PAR if configured (REQ-031), otherwise to DONE.
REQ-024 In DONE (one cycle), rd_done SHALL be 1 and sout_valid SHALL be 0; the next state SHALL be IDLE.
REQ-025 Latency: rd_start sampled at edge t → first valid bit in cycle t+2 → last bit in cycle t+N+1 → rd_done in cycle t+N+2 (plus one cycle when parity is enabled).
REQ-026 While rd_busy=1, rd_start SHALL be ignored (no queueing).
REQ-027 The readout SHALL use the LOAD-cycle snapshot; writebacks or serial loads during SHIFT SHALL NOT alter the bits being shifted out.
REQ-028 Outside SHIFT and PAR, sout SHALL be 0 and sout_valid SHALL be 0.

Reset
REQ-029 With rst_n=0 at an edge, reg0-reg2 SHALL be cleared to 0, the buffer and counter SHALL be cleared, the FSM SHALL return to IDLE, and sout, sout_valid, rd_busy and rd_done SHALL all be 0.
REQ-030 Reset mid-readout SHALL abort the readout without asserting rd_done; a rd_start on the first post-reset cycle SHALL be honoured.

Configuration
REQ-031 With the macro ASCON_READOUT_PARITY_EN defined, the PAR state SHALL exist: it lasts one cycle with sout set to the XOR of all N shifted bits (even parity) and sout_valid=1, then goes to DONE.
REQ-032 Without ASCON_READOUT_PARITY_EN, PAR and its accumulator SHALL be absent; SHIFT SHALL go directly to DONE.

Verification
REQ-033 Scenario: wrback_en=1, sel=1, val=128'h0123..CDEF → reg1_128b equals that value next cycle; reg0 and reg2 stay 0.
REQ-034 Scenario: 128 serial-load cycles into reg2 with alternating bits starting at 1 → reg2_128b=128'hAAAA...AAAA.
REQ-035 Scenario: rd_start, rd_sel=5, S_1_reg=64'h8000_0000_0000_0001 → 64 valid bits (1, then 62 zeros, then 1), rd_done in cycle t+66, rd_busy high for cycles t+1..t+66.
REQ-036 Scenario: readout of reg0=128'hFF.. with a writeback of 0 to reg0 during SHIFT, plus a second rd_start during SHIFT → all 128 bits read 1, no second readout occurs, and reg0=0 afterwards.
REQ-037 Scenario: same-cycle writeback and serial load to reg1 → writeback value wins; reset asserted at bit 40 of a readout → no rd_done and all outputs 0.
REQ-038 Scenario (ASCON_READOUT_PARITY_EN): readout of reg2=128'h7 → 129 valid bits, last bit 1; without the macro → 128 valid bits.
